// File: rtl/iser_frame_align_pkg.sv
// Shared types and defaults for the ISERDES frame-lane word aligner.
package iser_frame_align_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_e;

    localparam logic [15:0] DEF_FRAME_PATTERN = 16'hFF00;
    localparam int          DEF_LOSS_CNT      = 3;

endpackage

// File: rtl/iser_frame_align_lane.sv
// One lane of the aligner: 2-bit-per-cycle shift register plus the offset word window.
module iser_lane_window #(
    parameter int WORD_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           bits_i,
    input  logic [3:0]           offset_i,
    output logic [WORD_BITS-1:0] window_o
);
    localparam int SR_BITS = 2 * WORD_BITS;

    logic [SR_BITS-1:0] sr_q;
    logic [SR_BITS-1:0] sr_d;
    logic [SR_BITS+1:0] ext_s;

    // The window is cut from the freshly shifted value so the pair arriving on the
    // strobe cycle completes the word seen by that strobe.
    always_comb begin
        ext_s    = {sr_q, bits_i};
        sr_d     = ext_s[SR_BITS-1:0];
        window_o = WORD_BITS'(ext_s >> offset_i);
    end

    // Shift register, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/iser_frame_align.sv
// Word aligner for a DDR ADC link: slides the word window until the frame lane
// shows FRAME_PATTERN, then emits one aligned data word per word period.
module iser_frame_align
    import iser_frame_align_pkg::*;
#(
    parameter int          WORD_BITS     = 16,
    parameter logic [15:0] FRAME_PATTERN = DEF_FRAME_PATTERN,
    parameter int          LOSS_CNT      = DEF_LOSS_CNT
) (
    input  logic                 data_clk,
    input  logic                 rst,
    input  logic [1:0]           din,
    input  logic [1:0]           fin,
    input  logic                 align_en,
    output logic [WORD_BITS-1:0] dout,
    output logic                 dout_valid,
    output logic                 locked,
    output logic [3:0]           slip_offset,
    output logic                 align_err
);
    localparam int BEAT_W = (WORD_BITS / 2 > 1) ? $clog2(WORD_BITS / 2) : 1;
    localparam int MISS_W = $clog2(LOSS_CNT + 1);
    localparam logic [WORD_BITS-1:0] PATTERN = FRAME_PATTERN[WORD_BITS-1:0];

    align_state_e          state_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [MISS_W-1:0]     miss_q;
    logic [3:0]            off_q;
    logic [WORD_BITS-1:0]  dout_q;
    logic                  dout_valid_q;
    logic                  locked_q;
    logic                  align_err_q;

    logic [WORD_BITS-1:0]  data_win_s;
    logic [WORD_BITS-1:0]  frame_win_s;
    logic                  strobe_s;
    logic                  frame_match_s;

    iser_lane_window #(.WORD_BITS(WORD_BITS)) u_data_lane (
        .clk      (data_clk),
        .rst      (rst),
        .bits_i   (din),
        .offset_i (off_q),
        .window_o (data_win_s)
    );

    iser_lane_window #(.WORD_BITS(WORD_BITS)) u_frame_lane (
        .clk      (data_clk),
        .rst      (rst),
        .bits_i   (fin),
        .offset_i (off_q),
        .window_o (frame_win_s)
    );

    // Word-period strobe and frame-pattern comparison.
    always_comb begin
        strobe_s      = (beat_q == BEAT_W'(WORD_BITS / 2 - 1));
        frame_match_s = (frame_win_s == PATTERN);
    end

    // Alignment FSM with registered outputs; dout_valid is a one-cycle pulse.
    always_ff @(posedge data_clk) begin
        if (rst) begin
            state_q      <= ST_SEARCH;
            beat_q       <= '0;
            miss_q       <= '0;
            off_q        <= 4'd0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            beat_q       <= strobe_s ? '0 : beat_q + BEAT_W'(1);
            dout_valid_q <= 1'b0;
            if (!align_en) begin
                state_q  <= ST_SEARCH;
                miss_q   <= '0;
                locked_q <= 1'b0;
            end else if (strobe_s) begin
                case (state_q)
                    ST_SEARCH: begin
                        if (frame_match_s) begin
                            state_q      <= ST_LOCKED;
                            locked_q     <= 1'b1;
                            align_err_q  <= 1'b0;
                            miss_q       <= '0;
                            dout_q       <= data_win_s;
                            dout_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_SETTLE;
                            if (off_q == 4'(WORD_BITS - 1)) begin
                                off_q       <= 4'd0;
                                align_err_q <= 1'b1;
                            end else begin
                                off_q <= off_q + 4'd1;
                            end
                        end
                    end
                    // One strobe is skipped so the new offset sees a whole fresh word.
                    ST_SETTLE: begin
                        state_q <= ST_SEARCH;
                    end
                    ST_LOCKED: begin
                        dout_q       <= data_win_s;
                        dout_valid_q <= 1'b1;
                        if (frame_match_s) begin
                            miss_q <= '0;
                        end else if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
                            state_q  <= ST_SEARCH;
                            locked_q <= 1'b0;
                            miss_q   <= '0;
                        end else begin
                            miss_q <= miss_q + MISS_W'(1);
                        end
                    end
                    default: begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                        miss_q   <= '0;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign locked      = locked_q;
    assign slip_offset = off_q;
    assign align_err   = align_err_q;

endmodule

// File: tb/tb_iser_frame_align.sv
// Directed bench: drives bit-serial frame/data streams with a chosen phase and
// checks lock, offset search, loss of lock, align_en and reset behaviour.
module tb_iser_frame_align;

    localparam logic [15:0] BASE = 16'h0A00;

    logic        data_clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  din = 2'b00;
    logic [1:0]  fin = 2'b00;
    logic        align_en = 1'b1;
    logic [15:0] dout;
    logic        dout_valid;
    logic        locked;
    logic [3:0]  slip_offset;
    logic        align_err;

    int vectors = 0;
    int miscompares = 0;
    int k = 0;
    int ph = 0;
    bit fzero = 1'b0;
    bit corrupt_w [0:63];

    iser_frame_align dut (
        .data_clk    (data_clk),
        .rst         (rst),
        .din         (din),
        .fin         (fin),
        .align_en    (align_en),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .locked      (locked),
        .slip_offset (slip_offset),
        .align_err   (align_err)
    );

    always #5 data_clk = ~data_clk;

    function automatic logic [15:0] frame_word(input int w);
        if (fzero) return 16'h0000;
        if (w >= 0 && w < 64 && corrupt_w[w]) return 16'hFF01;
        return 16'hFF00;
    endfunction

    function automatic logic stream_bit(input bit is_frame, input int g);
        logic [15:0] wd;
        wd = is_frame ? frame_word(g / 16) : (BASE + 16'(g / 16));
        return wd[15 - (g % 16)];
    endfunction

    // Drive the pair for cycle k, take one clock edge, settle just after it.
    task automatic tick();
        int g;
        g = 2 * k + ph;
        din = {stream_bit(1'b0, g), stream_bit(1'b0, g + 1)};
        fin = {stream_bit(1'b1, g), stream_bit(1'b1, g + 1)};
        @(posedge data_clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int m);
        while (k < 8 * m + 8) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        align_en = 1'b1;
        @(posedge data_clk);
        #1;
        rst = 1'b0;
        k = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge data_clk);
        #1;
        vectors++;
        if ({dout, dout_valid, locked, slip_offset, align_err} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: dout=%h valid=%b locked=%b off=%0d err=%b, all required 0",
                     dout, dout_valid, locked, slip_offset, align_err);
        end
        rst = 1'b0;
        k = 0;
    endtask

    task automatic test_aligned();
        ph = 0; fzero = 1'b0;
        do_reset();
        run_to(0);
        vectors++;
        if (locked !== 1'b1 || dout_valid !== 1'b1 || dout !== BASE || slip_offset !== 4'd0) begin
            miscompares++;
            $display("FAIL aligned_first: locked=%b valid=%b dout=%h off=%0d, required 1 1 %h 0",
                     locked, dout_valid, dout, slip_offset, BASE);
        end
        for (int m = 1; m <= 4; m++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                vectors++;
                if (c == 7) begin
                    if (dout_valid !== 1'b1 || dout !== BASE + 16'(m)) begin
                        miscompares++;
                        $display("FAIL aligned_word: strobe %0d valid=%b dout=%h, required 1 %h",
                                 m, dout_valid, dout, BASE + 16'(m));
                    end
                end else if (dout_valid !== 1'b0 || dout !== BASE + 16'(m - 1)) begin
                    miscompares++;
                    $display("FAIL aligned_hold: cycle %0d valid=%b dout=%h, required 0 %h",
                             k, dout_valid, dout, BASE + 16'(m - 1));
                end
            end
        end
    endtask

    // Searching from offset 0 with the frame shifted by 5: lock lands on strobe 10.
    task automatic check_shift5_search();
        for (int m = 0; m <= 9; m++) begin
            run_to(m);
            vectors++;
            if (slip_offset !== 4'(m / 2 + 1) || locked !== 1'b0 || dout_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL shift5_search: strobe %0d off=%0d locked=%b valid=%b, required %0d 0 0",
                         m, slip_offset, locked, dout_valid, m / 2 + 1);
            end
        end
        run_to(10);
        vectors++;
        if (locked !== 1'b1 || slip_offset !== 4'd5 || dout_valid !== 1'b1 ||
            dout !== BASE + 16'd10 || align_err !== 1'b0) begin
            miscompares++;
            $display("FAIL shift5_lock: locked=%b off=%0d valid=%b dout=%h err=%b, required 1 5 1 %h 0",
                     locked, slip_offset, dout_valid, dout, align_err, BASE + 16'd10);
        end
    endtask

    task automatic test_shift5();
        ph = 5; fzero = 1'b0;
        do_reset();
        check_shift5_search();
        run_to(11);
        vectors++;
        if (dout_valid !== 1'b1 || dout !== BASE + 16'd11) begin
            miscompares++;
            $display("FAIL shift5_next: valid=%b dout=%h, required 1 %h", dout_valid, dout, BASE + 16'd11);
        end
    endtask

    task automatic test_const0();
        int valid_seen;
        int lock_seen;
        valid_seen = 0; lock_seen = 0;
        ph = 0; fzero = 1'b1;
        do_reset();
        for (int m = 0; m <= 33; m++) begin
            while (k < 8 * m + 8) begin
                tick();
                if (dout_valid !== 1'b0) valid_seen++;
                if (locked !== 1'b0) lock_seen++;
            end
            vectors++;
            if (slip_offset !== 4'((m / 2 + 1) % 16) || align_err !== (m >= 30)) begin
                miscompares++;
                $display("FAIL const0_offset: strobe %0d off=%0d err=%b, required %0d %b",
                         m, slip_offset, align_err, (m / 2 + 1) % 16, (m >= 30));
            end
        end
        vectors++;
        if (valid_seen !== 0 || lock_seen !== 0) begin
            miscompares++;
            $display("FAIL const0_never: valid cycles=%0d locked cycles=%0d, required 0 0", valid_seen, lock_seen);
        end
        align_en = 1'b0;
        repeat (16) tick();
        vectors++;
        if (slip_offset !== 4'd1 || align_err !== 1'b1 || dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL const0_disabled: off=%0d err=%b valid=%b, required 1 1 0",
                     slip_offset, align_err, dout_valid);
        end
        align_en = 1'b1;
        fzero = 1'b0;
    endtask

    task automatic test_align_en();
        int valid_seen;
        valid_seen = 0;
        ph = 0; fzero = 1'b0;
        do_reset();
        run_to(1);
        align_en = 1'b0;
        tick();
        vectors++;
        if (locked !== 1'b0 || dout_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL en_drop: locked=%b valid=%b, required 0 0", locked, dout_valid);
        end
        while (k < 32) begin
            tick();
            if (dout_valid !== 1'b0) valid_seen++;
        end
        vectors++;
        if (valid_seen !== 0 || slip_offset !== 4'd0 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL en_low: valid cycles=%0d off=%0d locked=%b, required 0 0 0",
                     valid_seen, slip_offset, locked);
        end
        align_en = 1'b1;
        run_to(4);
        vectors++;
        if (locked !== 1'b1 || dout_valid !== 1'b1 || dout !== BASE + 16'd4) begin
            miscompares++;
            $display("FAIL en_relock: locked=%b valid=%b dout=%h, required 1 1 %h",
                     locked, dout_valid, dout, BASE + 16'd4);
        end
    endtask

    task automatic test_loss();
        ph = 0; fzero = 1'b0;
        corrupt_w[3] = 1'b1; corrupt_w[4] = 1'b1;
        corrupt_w[7] = 1'b1; corrupt_w[8] = 1'b1; corrupt_w[9] = 1'b1;
        do_reset();
        for (int m = 3; m <= 8; m++) begin
            run_to(m);
            vectors++;
            if (locked !== 1'b1 || dout_valid !== 1'b1 || dout !== BASE + 16'(m)) begin
                miscompares++;
                $display("FAIL loss_hold: strobe %0d locked=%b valid=%b dout=%h, required 1 1 %h",
                         m, locked, dout_valid, dout, BASE + 16'(m));
            end
        end
        run_to(9);
        vectors++;
        if (locked !== 1'b0 || dout_valid !== 1'b1 || dout !== BASE + 16'd9) begin
            miscompares++;
            $display("FAIL loss_drop: locked=%b valid=%b dout=%h, required 0 1 %h",
                     locked, dout_valid, dout, BASE + 16'd9);
        end
        run_to(10);
        vectors++;
        if (locked !== 1'b1 || slip_offset !== 4'd0 || dout !== BASE + 16'd10) begin
            miscompares++;
            $display("FAIL loss_relock: locked=%b off=%0d dout=%h, required 1 0 %h",
                     locked, slip_offset, dout, BASE + 16'd10);
        end
        for (int i = 0; i < 64; i++) corrupt_w[i] = 1'b0;
    endtask

    task automatic test_rst_midlock();
        ph = 5; fzero = 1'b0;
        do_reset();
        run_to(10);
        while (k < 8 * 11 + 7) tick();
        rst = 1'b1;
        align_en = 1'b0;
        tick();
        vectors++;
        if ({dout, dout_valid, locked, slip_offset, align_err} !== 23'd0) begin
            miscompares++;
            $display("FAIL rst_midlock: dout=%h valid=%b locked=%b off=%0d err=%b, all required 0",
                     dout, dout_valid, locked, slip_offset, align_err);
        end
        rst = 1'b0;
        align_en = 1'b1;
        k = 0;
        check_shift5_search();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) corrupt_w[i] = 1'b0;
        test_reset();
        test_aligned();
        test_shift5();
        test_const0();
        test_align_en();
        test_loss();
        test_rst_midlock();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
